// File: rtl/dtree_class_voter_if.sv
// dtree_class_voter_if: classifier-to-voter and voter-to-system handshake bundle
// Signals: in_valid/in_ready/class_in (upstream beat), out_valid/out_ready/class_out (vote result),
// err_class (sticky bad-code flag); conf_out/unanimous exist only when VOTER_CONF_EN is defined.
// master drives class beats and accepts results; slave is the voter.
interface dtree_class_voter_if #(
  parameter int CLASS_W = 5,
  parameter int CNT_W = 4
);
  logic in_valid;
  logic in_ready;
  logic [CLASS_W-1:0] class_in;
  logic out_valid;
  logic out_ready;
  logic [CLASS_W-1:0] class_out;
  logic err_class;
`ifdef VOTER_CONF_EN
  logic [CNT_W-1:0] conf_out;
  logic unanimous;
`endif
  modport master (
    output in_valid, class_in, out_ready,
    input in_ready, out_valid, class_out, err_class
`ifdef VOTER_CONF_EN
    , input conf_out, unanimous
`endif
  );
  modport slave (
    input in_valid, class_in, out_ready,
    output in_ready, out_valid, class_out, err_class
`ifdef VOTER_CONF_EN
    , output conf_out, unanimous
`endif
  );
endinterface

// File: rtl/dtree_class_voter.sv
// dtree_class_voter: majority vote over WINDOW decision-tree class codes, sequential scan, valid/ready result
// Ports: clk, rst_n (sync active-low), bus (dtree_class_voter_if.slave).
// Optional VOTER_CONF_EN adds conf_out (winning vote count) and unanimous on the bus.
module dtree_class_voter #(
  parameter int CLASS_W = 5,
  parameter int NUM_CLASSES = 16,
  parameter int WINDOW = 8,
  parameter int CNT_W = $clog2(WINDOW + 1)
) (
  input logic clk,
  input logic rst_n,
  dtree_class_voter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CLASSES);
  typedef enum logic [1:0] {ACCUM, SCAN, HOLD} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt [NUM_CLASSES];
  logic [CNT_W-1:0] samples, best_cnt;
  logic [IDX_W-1:0] idx, best_idx;
  logic [CLASS_W-1:0] class_q;
  logic err_q, full, last, in_hs, out_hs, code_ok, better;
  // full window holds in_ready low for one ACCUM cycle before the scan starts
  always_comb begin
    full = samples == CNT_W'(WINDOW);
    last = idx == IDX_W'(NUM_CLASSES - 1);
    code_ok = int'(bus.class_in) < NUM_CLASSES;
    in_hs = bus.in_valid && bus.in_ready;
    out_hs = bus.out_valid && bus.out_ready;
    better = cnt[idx] > best_cnt;
    state_d = state_q == ACCUM ? (full ? SCAN : ACCUM)
            : state_q == SCAN ? (last ? HOLD : SCAN)
            : (bus.out_ready ? ACCUM : HOLD);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
      samples <= '0;
      best_cnt <= '0;
      best_idx <= '0;
      idx <= '0;
      class_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_hs) begin
        if (code_ok) begin
          cnt[bus.class_in[IDX_W-1:0]] <= cnt[bus.class_in[IDX_W-1:0]] + 1'b1;
          samples <= samples + 1'b1;
        end else err_q <= 1'b1;
      end
      // strict compare keeps the lowest index on ties
      if (state_q == SCAN) begin
        if (better) begin
          best_cnt <= cnt[idx];
          best_idx <= idx;
        end
        idx <= last ? '0 : idx + 1'b1;
        if (last) class_q <= CLASS_W'(better ? idx : best_idx);
      end
      if (out_hs) begin
        for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
        samples <= '0;
        best_cnt <= '0;
        best_idx <= '0;
        err_q <= 1'b0;
      end
    end
  end
  assign bus.in_ready = state_q == ACCUM && !full;
  assign bus.out_valid = state_q == HOLD;
  assign bus.class_out = class_q;
  assign bus.err_class = err_q;
`ifdef VOTER_CONF_EN
  assign bus.conf_out = best_cnt;
  assign bus.unanimous = bus.out_valid && best_cnt == CNT_W'(WINDOW);
`endif
endmodule

// File: tb/tb_dtree_class_voter.sv
// tb_dtree_class_voter: scoreboard bench for dtree_class_voter with directed vote windows
module tb_dtree_class_voter;
  logic clk, rst_n;
  int compared, mismatched, cyc, hs_cyc, rise_cyc;
  logic prev_ov;
  typedef struct {int cls; int err; int conf; int unan;} exp_t;
  exp_t sb[$];
  dtree_class_voter_if #(.CLASS_W(5), .CNT_W(4)) bus ();
  dtree_class_voter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && !prev_ov) rise_cyc = cyc;
    prev_ov = bus.out_valid;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("class_out", int'(bus.class_out), e.cls);
        chk("err_class", int'(bus.err_class), e.err);
`ifdef VOTER_CONF_EN
        chk("conf_out", int'(bus.conf_out), e.conf);
        chk("unanimous", int'(bus.unanimous), e.unan);
`endif
      end
    end
  end
  task automatic push(input int cls, input int err, input int conf, input int unan);
    exp_t e;
    e.cls = cls; e.err = err; e.conf = conf; e.unan = unan;
    sb.push_back(e);
  endtask
  task automatic send(input int c);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.class_in = 5'(c);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1 hs_cyc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic send_win(input int v[]);
    foreach (v[i]) send(v[i]);
  endtask
  task automatic wait_result();
    int n = 0;
    while (!(bus.out_valid && bus.out_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("result_timeout", 0, 1);
    @(negedge clk);
  endtask
  initial begin
    compared = 0; mismatched = 0; cyc = 0; prev_ov = 1'b0;
    bus.in_valid = 1'b0; bus.class_in = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_class_out", int'(bus.class_out), 0);
    chk("rst_err_class", int'(bus.err_class), 0);
    push(3, 0, 8, 1);
    send_win('{3, 3, 3, 3, 3, 3, 3, 3});
    chk("full_in_ready", int'(bus.in_ready), 0);
    wait_result();
    chk("latency", rise_cyc - hs_cyc, 17);
    chk("post_hs_in_ready", int'(bus.in_ready), 1);
    push(5, 0, 4, 0);
    send_win('{2, 5, 5, 2, 5, 7, 2, 5});
    wait_result();
    push(1, 0, 4, 0);
    send_win('{6, 6, 6, 6, 1, 1, 1, 1});
    wait_result();
    push(4, 1, 8, 1);
    send(4);
    send(20);
    chk("err_set", int'(bus.err_class), 1);
    send_win('{4, 4, 4, 4, 4, 4});
    chk("window_open_after_8", int'(bus.in_ready), 1);
    send(4);
    wait_result();
    chk("err_cleared", int'(bus.err_class), 0);
    bus.out_ready = 1'b0;
    push(5, 0, 5, 0);
    send_win('{5, 5, 5, 5, 5, 3, 3, 3});
    for (int n = 0; n < 200 && !bus.out_valid; n++) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.class_in = 5'd9;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_class_out", int'(bus.class_out), 5);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_result();
    push(1, 0, 5, 0);
    send_win('{9, 9, 9, 1, 1, 1, 1, 1});
    wait_result();
    send_win('{2, 2, 2, 2, 2, 2, 2, 2});
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("scan_rst_out_valid", int'(bus.out_valid), 0);
    chk("scan_rst_in_ready", int'(bus.in_ready), 1);
    chk("scan_rst_class_out", int'(bus.class_out), 0);
    repeat (25) @(negedge clk);
    chk("scan_rst_no_result", int'(bus.out_valid), 0);
    push(7, 0, 8, 1);
    send_win('{7, 7, 7, 7, 7, 7, 7, 7});
    wait_result();
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
